dm_arbiter: RTL and testbench

- Arbitrates the single-port data memory (async read, sync write) between the multi-cycle CPU datapath and an external requester (loader/DMA/debug).
- Sits between the CPU store/load path and dm, and between an external port and dm.
- Fixed three-cycle access sequence per transaction: sample, access, respond.
- Round-robin fairness; a lock input lets the external side take a bounded burst of consecutive grants.

---
 rtl/dm_arbiter.sv | 126 ++++++++++++
 tb/tb_dm_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares the single-port dm between the CPU and an external requester
// using a fixed IDLE -> ACC -> RESP sequence, round-robin with a bounded external lock burst.
module dm_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter int EXT_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              busy
);

    localparam int STREAK_W = $clog2(EXT_BURST_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(EXT_BURST_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_t;

    state_t              state;
    owner_t              owner;
    owner_t              last_grant;
    logic [STREAK_W-1:0] ext_streak;
    logic                grant_cpu;
    logic                grant_ext;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        if (cpu_req && ext_req) begin
            if (ext_lock && last_grant == OWN_EXT && ext_streak < STREAK_MAX)
                grant_ext = 1'b1;
            else if (last_grant == OWN_EXT)
                grant_cpu = 1'b1;
            else
                grant_ext = 1'b1;
        end else if (cpu_req) begin
            grant_cpu = 1'b1;
        end else if (ext_req) begin
            grant_ext = 1'b1;
        end
    end

    // dm_addr/dm_din/dm_we double as the latched copy of the owner's request.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            last_grant <= OWN_EXT;
            ext_streak <= '0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
            cpu_ack    <= 1'b0;
            ext_ack    <= 1'b0;
            dm_addr    <= '0;
            dm_din     <= '0;
            dm_we      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_cpu) begin
                        owner      <= OWN_CPU;
                        last_grant <= OWN_CPU;
                        ext_streak <= '0;
                        dm_addr    <= cpu_addr;
                        dm_din     <= cpu_wdata;
                        dm_we      <= cpu_we;
                        busy       <= 1'b1;
                        state      <= ST_ACC;
                    end else if (grant_ext) begin
                        owner      <= OWN_EXT;
                        last_grant <= OWN_EXT;
                        if (!cpu_req)
                            ext_streak <= '0;
                        else if (ext_streak < STREAK_MAX)
                            ext_streak <= ext_streak + 1'b1;
                        dm_addr    <= ext_addr;
                        dm_din     <= ext_wdata;
                        dm_we      <= ext_we;
                        busy       <= 1'b1;
                        state      <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    // dm_we still holds the latched direction; reads capture the async data.
                    if (!dm_we) begin
                        if (owner == OWN_CPU) cpu_rdata <= dm_rdata;
                        if (owner == OWN_EXT) ext_rdata <= dm_rdata;
                    end
                    dm_we   <= 1'b0;
                    cpu_ack <= (owner == OWN_CPU);
                    ext_ack <= (owner == OWN_EXT);
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    cpu_ack <= 1'b0;
                    ext_ack <= 1'b0;
                    busy    <= 1'b0;
                    owner   <= OWN_NONE;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a behavioural dm model plus per-scenario tasks with
// hand-computed expectations for timing, grant order, data paths and reset.
module tb_dm_arbiter;

    localparam int ADDR_W        = 10;
    localparam int DATA_W        = 32;
    localparam int EXT_BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_ack;
    logic              ext_req, ext_we, ext_lock;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata, ext_rdata;
    logic              ext_ack;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_din, dm_rdata;
    logic              dm_we, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dm_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .EXT_BURST_MAX(EXT_BURST_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_rdata(dm_rdata),
        .busy(busy)
    );

    // Unwritten words read back as 0xC0DE_0000 | address.
    bit [DATA_W-1:0] mem     [1024];
    bit              written [1024];

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return written[a] ? mem[a] : (32'hC0DE_0000 | {22'd0, a});
    endfunction

    assign dm_rdata = mem_word(dm_addr);

    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr]     <= dm_din;
            written[dm_addr] <= 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        n_tests++;
        if ({cpu_rdata, ext_rdata, dm_addr, dm_din, cpu_ack, ext_ack, dm_we, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cpu_rdata=%h ext_rdata=%h dm_addr=%h dm_din=%h acks=%b%b dm_we=%b busy=%b, expected all 0",
                     cpu_rdata, ext_rdata, dm_addr, dm_din, cpu_ack, ext_ack, dm_we, busy);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if ({busy, dm_we, cpu_ack, ext_ack} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy/we/acks=%b, expected 0000", {busy, dm_we, cpu_ack, ext_ack});
        end
    endtask

    task automatic test_reset_mid_acc;
        ext_req = 1; ext_we = 1; ext_addr = 10'h010; ext_wdata = 32'hDEAD_BEEF;
        tick();
        n_tests++;
        if ({dm_we, busy, dm_addr} !== {1'b1, 1'b1, 10'h010}) begin
            n_fail++;
            $display("FAIL ext_write_acc: got dm_we=%b busy=%b dm_addr=%h, expected 1 1 010", dm_we, busy, dm_addr);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({cpu_rdata, ext_rdata, dm_addr, dm_din, cpu_ack, ext_ack, dm_we, busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_mid_acc: got dm_we=%b busy=%b dm_addr=%h dm_din=%h, expected all 0",
                     dm_we, busy, dm_addr, dm_din);
        end
        ext_req = 0;
        tick();
        n_tests++;
        if (mem_word(10'h010) !== 32'hC0DE_0010) begin
            n_fail++;
            $display("FAIL aborted_write: got mem[010]=%h, expected c0de0010", mem_word(10'h010));
        end
        reset = 1'b1;
        // Contested request right after reset: CPU read must win, then the ext write.
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
        ext_req = 1; ext_we = 1; ext_addr = 10'h020; ext_wdata = 32'h0BAD_F00D; ext_lock = 0;
        tick();
        n_tests++;
        if ({dm_addr, dm_we} !== {10'h010, 1'b0}) begin
            n_fail++;
            $display("FAIL first_grant_cpu: got dm_addr=%h dm_we=%b, expected 010 0", dm_addr, dm_we);
        end
        tick();
        n_tests++;
        if ({cpu_ack, ext_ack, cpu_rdata} !== {2'b10, 32'hC0DE_0010}) begin
            n_fail++;
            $display("FAIL first_cpu_ack: got acks=%b cpu_rdata=%h, expected 10 c0de0010", {cpu_ack, ext_ack}, cpu_rdata);
        end
        cpu_req = 0;
        tick();
        tick();
        n_tests++;
        if ({dm_we, dm_addr, dm_din} !== {1'b1, 10'h020, 32'h0BAD_F00D}) begin
            n_fail++;
            $display("FAIL second_grant_ext: got dm_we=%b dm_addr=%h dm_din=%h, expected 1 020 0badf00d", dm_we, dm_addr, dm_din);
        end
        tick();
        n_tests++;
        if ({cpu_ack, ext_ack} !== 2'b01) begin
            n_fail++;
            $display("FAIL ext_write_ack: got acks=%b, expected 01", {cpu_ack, ext_ack});
        end
        ext_req = 0;
        tick();
        n_tests++;
        if ({mem_word(10'h020), ext_rdata, busy} !== {32'h0BAD_F00D, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL ext_write_result: got mem[020]=%h ext_rdata=%h busy=%b, expected 0badf00d 0 0",
                     mem_word(10'h020), ext_rdata, busy);
        end
    endtask

    task automatic test_cpu_write_read;
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h004; cpu_wdata = 32'h1234_5678;
        tick();
        n_tests++;
        if ({dm_we, dm_addr, dm_din, cpu_ack, busy} !== {1'b1, 10'h004, 32'h1234_5678, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL cpu_write_acc: got dm_we=%b dm_addr=%h dm_din=%h cpu_ack=%b busy=%b, expected 1 004 12345678 0 1",
                     dm_we, dm_addr, dm_din, cpu_ack, busy);
        end
        tick();
        n_tests++;
        if ({cpu_ack, ext_ack, dm_we, busy, dm_addr} !== {4'b1001, 10'h004}) begin
            n_fail++;
            $display("FAIL cpu_write_resp: got ack/ext/we/busy=%b dm_addr=%h, expected 1001 004",
                     {cpu_ack, ext_ack, dm_we, busy}, dm_addr);
        end
        cpu_req = 0;
        tick();
        n_tests++;
        if ({cpu_ack, busy, mem_word(10'h004)} !== {2'b00, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL cpu_write_done: got cpu_ack=%b busy=%b mem[004]=%h, expected 0 0 12345678",
                     cpu_ack, busy, mem_word(10'h004));
        end
        cpu_req = 1; cpu_we = 0; cpu_wdata = 32'hFFFF_FFFF;
        tick();
        n_tests++;
        if ({dm_we, cpu_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL cpu_read_acc: got dm_we=%b cpu_ack=%b, expected 0 0", dm_we, cpu_ack);
        end
        tick();
        n_tests++;
        if ({cpu_ack, cpu_rdata, ext_rdata} !== {1'b1, 32'h1234_5678, 32'h0}) begin
            n_fail++;
            $display("FAIL cpu_read_resp: got cpu_ack=%b cpu_rdata=%h ext_rdata=%h, expected 1 12345678 0",
                     cpu_ack, cpu_rdata, ext_rdata);
        end
        cpu_req = 0;
        tick();
    endtask

    // Both sides request continuously; acks land every third cycle and alternate.
    task automatic test_round_robin;
        int ack_idx = 0;
        logic exp_ext;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h100;
        ext_req = 1; ext_we = 0; ext_addr = 10'h200; ext_lock = 0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            n_tests++;
            if (c % 3 == 2) begin
                exp_ext = (ack_idx % 2 == 0);
                if ({cpu_ack, ext_ack} !== {~exp_ext, exp_ext}) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got acks=%b, expected %b", ack_idx, {cpu_ack, ext_ack}, {~exp_ext, exp_ext});
                end
                n_tests++;
                if ((exp_ext ? ext_rdata : cpu_rdata) !== (exp_ext ? 32'hC0DE_0200 : 32'hC0DE_0100)) begin
                    n_fail++;
                    $display("FAIL rr_rdata[%0d]: got %h, expected %h", ack_idx,
                             exp_ext ? ext_rdata : cpu_rdata, exp_ext ? 32'hC0DE_0200 : 32'hC0DE_0100);
                end
                ack_idx++;
            end else if ({cpu_ack, ext_ack} !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_spurious_ack cycle %0d: got acks=%b, expected 00", c, {cpu_ack, ext_ack});
            end
        end
        cpu_req = 0; ext_req = 0;
        tick();
    endtask

    // Locked ext side gets EXT_BURST_MAX grants, then one CPU grant, repeating.
    task automatic test_ext_lock_burst;
        logic [9:0] pattern = 10'b0111101111;
        int ack_idx = 0;
        logic exp_ext;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h100;
        ext_req = 1; ext_we = 0; ext_addr = 10'h200; ext_lock = 1;
        for (int c = 1; c <= 29; c++) begin
            tick();
            n_tests++;
            if (c % 3 == 2) begin
                exp_ext = pattern[ack_idx];
                if ({cpu_ack, ext_ack} !== {~exp_ext, exp_ext}) begin
                    n_fail++;
                    $display("FAIL burst_order[%0d]: got acks=%b, expected %b", ack_idx, {cpu_ack, ext_ack}, {~exp_ext, exp_ext});
                end
                ack_idx++;
            end else if ({cpu_ack, ext_ack} !== 2'b00) begin
                n_fail++;
                $display("FAIL burst_spurious_ack cycle %0d: got acks=%b, expected 00", c, {cpu_ack, ext_ack});
            end
        end
        cpu_req = 0; ext_req = 0; ext_lock = 0;
        tick();
    endtask

    task automatic test_ext_only_lock;
        ext_req = 1; ext_we = 0; ext_addr = 10'h300; ext_lock = 1;
        for (int c = 1; c <= 29; c++) begin
            tick();
            n_tests++;
            if (c % 3 == 2) begin
                if ({cpu_ack, ext_ack, ext_rdata} !== {2'b01, 32'hC0DE_0300}) begin
                    n_fail++;
                    $display("FAIL ext_stream cycle %0d: got acks=%b ext_rdata=%h, expected 01 c0de0300",
                             c, {cpu_ack, ext_ack}, ext_rdata);
                end
            end else if ({cpu_ack, ext_ack} !== 2'b00) begin
                n_fail++;
                $display("FAIL ext_stream_spurious cycle %0d: got acks=%b, expected 00", c, {cpu_ack, ext_ack});
            end
            if (c == 28) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 10'h100;
            end
            if (c == 29) begin
                ext_req = 0; ext_lock = 0;
            end
        end
        tick();
        n_tests++;
        if ({busy, cpu_ack, ext_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL cpu_wait_idle: got busy/acks=%b, expected 000", {busy, cpu_ack, ext_ack});
        end
        tick();
        n_tests++;
        if ({busy, dm_addr} !== {1'b1, 10'h100}) begin
            n_fail++;
            $display("FAIL cpu_after_stream_acc: got busy=%b dm_addr=%h, expected 1 100", busy, dm_addr);
        end
        tick();
        n_tests++;
        if ({cpu_ack, ext_ack, cpu_rdata} !== {2'b10, 32'hC0DE_0100}) begin
            n_fail++;
            $display("FAIL cpu_after_stream_ack: got acks=%b cpu_rdata=%h, expected 10 c0de0100", {cpu_ack, ext_ack}, cpu_rdata);
        end
        cpu_req = 0;
        tick();
    endtask

    // Ext read of the top word while the CPU waits; the CPU's later access uses its IDLE-sampled address.
    task automatic test_addr_hold;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h100;
        ext_req = 1; ext_we = 0; ext_addr = 10'h3FF; ext_lock = 0;
        tick();
        n_tests++;
        if (dm_addr !== 10'h3FF) begin
            n_fail++;
            $display("FAIL top_addr_acc: got dm_addr=%h, expected 3ff", dm_addr);
        end
        cpu_addr = 10'h004;
        tick();
        n_tests++;
        if ({cpu_ack, ext_ack, ext_rdata, cpu_rdata} !== {2'b01, 32'hC0DE_03FF, 32'hC0DE_0100}) begin
            n_fail++;
            $display("FAIL top_addr_ack: got acks=%b ext_rdata=%h cpu_rdata=%h, expected 01 c0de03ff c0de0100",
                     {cpu_ack, ext_ack}, ext_rdata, cpu_rdata);
        end
        ext_req = 0;
        tick();
        tick();
        n_tests++;
        if (dm_addr !== 10'h004) begin
            n_fail++;
            $display("FAIL cpu_sampled_addr: got dm_addr=%h, expected 004", dm_addr);
        end
        cpu_addr = 10'h200;
        tick();
        n_tests++;
        if ({cpu_ack, cpu_rdata, dm_addr, ext_rdata} !== {1'b1, 32'h1234_5678, 10'h004, 32'hC0DE_03FF}) begin
            n_fail++;
            $display("FAIL cpu_latched_read: got cpu_ack=%b cpu_rdata=%h dm_addr=%h ext_rdata=%h, expected 1 12345678 004 c0de03ff",
                     cpu_ack, cpu_rdata, dm_addr, ext_rdata);
        end
        cpu_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid_acc();
        test_cpu_write_read();
        test_round_robin();
        test_ext_lock_burst();
        test_ext_only_lock();
        test_addr_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
